// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU and response signals of alu_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding logic: both requesters, the ALU instance and the response consumer.
//   req0_* / req1_* : valid/ready request channels (op, signed a/b, shamt)
//   alu_*           : operands out to the shared ALU, result and overflow back
//   rsp_*           : tagged response channel (valid/ready)
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req0_shamt;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [4:0]  req1_shamt;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_overflow;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_ovf;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    output req1_ready,
    output alu_a, alu_b, alu_op, alu_shamt,
    input  alu_result, alu_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    input  req1_ready,
    input  alu_a, alu_b, alu_op, alu_shamt,
    output alu_result, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: two-requester round-robin arbiter and sequencer for the shared 32-bit ALU.
// Latency: request handshake in cycle N, then EXEC in N+1, then rsp_valid in N+2.
//          At most one op is accepted every 3 cycles.
// Backpressure: the response is held stable while rsp_ready is low. Both request
//               readies stay low from acceptance until the response is taken.
//
// Ports:
//   clk, rst_n       : clock (rising edge) and synchronous active-low reset
//   bus (slave)      : req0/req1 request channels, alu_* to/from the ALU, rsp_* response
//   ovf_sticky[1:0]  : per-requester sticky overflow flags (only with ALU_OVF_STICKY_EN)
//   ovf_clr[1:0]     : per-requester clear of those flags (only with ALU_OVF_STICKY_EN)
//
// Optional feature macro: ALU_OVF_STICKY_EN adds the sticky overflow flags.
module alu_arbiter #(
  parameter int unsigned RR_INIT = 0,  // requester that holds priority after reset
  parameter int unsigned OP_MAX  = 8   // highest legal op code
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ALU_OVF_STICKY_EN
  output logic [1:0] ovf_sticky,
  input  logic [1:0] ovf_clr,
`endif
  alu_arbiter_if.slave bus
);

  // The op code is only 4 bits wide, so any OP_MAX of 15 or more makes every code legal.
  localparam int unsigned OP_LIM      = (OP_MAX > 15) ? 15 : OP_MAX;
  localparam logic [3:0]  OP_LIM_C    = 4'(OP_LIM);
  localparam logic        RR_INIT_BIT = (RR_INIT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Arbitration
  logic        prio_q;
  logic        gnt_id;
  logic        any_vld;
  logic        req0_rdy;
  logic        req1_rdy;
  logic        hs;

  // Selected request fields (muxed on the grant)
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [4:0]  sel_shamt;
  logic        sel_illegal;

  // Operand registers. These registers drive the ALU directly. They load only on
  // a request handshake, so the ALU inputs stay at their last issued values
  // outside EXEC.
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [4:0]  alu_shamt_q;
  logic        id_q;
  logic        illegal_q;
  logic        arith_q;     // latched op is add or sub: only these report overflow

  // Response registers, written only at the end of EXEC
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_ovf_q;
  logic        rsp_err_q;

  logic        cap_ovf;     // overflow value captured at the end of EXEC

  // ------------------------------------------------------------------------
  // Grant selection. Priority matters only when both requesters are valid.
  // Otherwise the single valid requester wins. The ready outputs are gated
  // with rst_n so that no handshake can appear to happen while reset is applied.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    req0_rdy = 1'b0;
    req1_rdy = 1'b0;
    hs       = 1'b0;
    any_vld  = bus.req0_valid | bus.req1_valid;
    gnt_id   = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;

    case (state_q)
      IDLE: begin
        if (rst_n && any_vld) begin
          req0_rdy = ~gnt_id;
          req1_rdy = gnt_id;
          hs       = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request mux on the granted requester
  always_comb begin
    sel_op      = gnt_id ? bus.req1_op    : bus.req0_op;
    sel_a       = gnt_id ? bus.req1_a     : bus.req0_a;
    sel_b       = gnt_id ? bus.req1_b     : bus.req0_b;
    sel_shamt   = gnt_id ? bus.req1_shamt : bus.req0_shamt;
    sel_illegal = (sel_op > OP_LIM_C);
  end

  // Overflow counts only for a legal add or sub. The ALU's overflow output is
  // ignored for every other op.
  assign cap_ovf = ~illegal_q & arith_q & bus.alu_overflow;

  // ------------------------------------------------------------------------
  // Operand and response datapath
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q       <= RR_INIT_BIT;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_shamt_q  <= '0;
      id_q         <= 1'b0;
      illegal_q    <= 1'b0;
      arith_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (hs) begin
        alu_a_q     <= sel_a;
        alu_b_q     <= sel_b;
        alu_shamt_q <= sel_shamt;
        // An illegal code is never presented to the ALU. The previous op stays
        // on alu_op.
        if (!sel_illegal) begin
          alu_op_q <= sel_op;
        end
        id_q      <= gnt_id;
        illegal_q <= sel_illegal;
        arith_q   <= (sel_op < 4'd2);
        prio_q    <= ~gnt_id;
      end

      if (state_q == EXEC) begin
        rsp_id_q <= id_q;
        if (illegal_q) begin
          rsp_result_q <= '0;
          rsp_ovf_q    <= 1'b0;
          rsp_err_q    <= 1'b1;
        end else begin
          rsp_result_q <= bus.alu_result;
          rsp_ovf_q    <= cap_ovf;
          rsp_err_q    <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_OVF_STICKY_EN
  // Sticky overflow flags. If a set and a clear hit the same bit in the same
  // cycle, the set wins, so an overflow is never lost to a clear.
  logic [1:0] sticky_q;
  logic [1:0] sticky_set;

  always_comb begin
    sticky_set = 2'b00;
    if (state_q == EXEC && cap_ovf) begin
      sticky_set = id_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= (sticky_q & ~ovf_clr) | sticky_set;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.req0_ready = req0_rdy;
  assign bus.req1_ready = req1_rdy;

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_shamt  = alu_shamt_q;

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int OP_MAX = 8;

  logic clk;
  logic rst_n;

  alu_arbiter_if bus ();

`ifdef ALU_OVF_STICKY_EN
  logic [1:0] ovf_sticky;
  logic [1:0] ovf_clr;
`endif

  alu_arbiter #(.RR_INIT(0), .OP_MAX(OP_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_OVF_STICKY_EN
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
`endif
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int hs_count = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout (t=%0t)", name, $time);
  endtask

  // Environment ALU. For ops other than sub, its overflow output is the add
  // overflow of the operands. The arbiter must therefore mask overflow itself.
  logic [31:0] alu_sum, alu_dif;
  assign alu_sum = bus.alu_a + bus.alu_b;
  assign alu_dif = bus.alu_a - bus.alu_b;

  always_comb begin
    bus.alu_result = 32'h0;
    case (bus.alu_op)
      4'd0: bus.alu_result = alu_sum;
      4'd1: bus.alu_result = alu_dif;
      4'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      4'd4: bus.alu_result = bus.alu_a << bus.alu_shamt;
      4'd5: bus.alu_result = bus.alu_a >> bus.alu_shamt;
      4'd6: bus.alu_result = 32'($signed(bus.alu_a) >>> bus.alu_shamt);
      4'd7: bus.alu_result = {31'b0, $signed(bus.alu_a) > $signed(bus.alu_b)};
      4'd8: bus.alu_result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
    if (bus.alu_op == 4'd1)
      bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_dif[31] != bus.alu_a[31]);
    else
      bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
    logic        err;
    int          hs_cycle;
  } exp_t;

  exp_t exp_q[$];
  exp_t rsp_log[$];

  // Reference result computed with wide signed arithmetic
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic o,
                                  output logic e);
    longint sa, sb, w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; o = 1'b0; e = 1'b0;
    if (op > OP_MAX) begin
      e = 1'b1;
    end else begin
      case (op)
        4'd0: w = sa + sb;
        4'd1: w = sa - sb;
        default: w = 0;
      endcase
      case (op)
        4'd0, 4'd1: begin
          r = w[31:0];
          o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
        end
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a << sh;
        4'd5: r = a >> sh;
        4'd6: r = 32'(sa >>> sh);
        4'd7: r = (sa > sb) ? 32'd1 : 32'd0;
        4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
        default: r = 32'h0;
      endcase
    end
  endfunction

  logic        m_prio;
  logic [31:0] m_alu_a, m_alu_b;
  logic [3:0]  m_alu_op;
  logic [4:0]  m_alu_sh;
  logic        m_in_exec;
  logic [1:0]  m_sticky;

  always @(negedge clk) begin
    logic busy, e_r0, e_r1, e_vld, v0, v1, gid;
    logic [3:0] op; logic [31:0] a, b; logic [4:0] sh;
    exp_t t;
    if (!rst_n) begin
      exp_q.delete();
      m_prio = 1'b0;
      m_alu_a = 0; m_alu_b = 0; m_alu_op = 0; m_alu_sh = 0;
      m_in_exec = 1'b0;
      m_sticky = 2'b00;
    end else begin
      busy = (exp_q.size() != 0);
      v0 = bus.req0_valid; v1 = bus.req1_valid;
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!busy) begin
        if (v0 && v1) begin e_r0 = (m_prio == 1'b0); e_r1 = (m_prio == 1'b1); end
        else begin e_r0 = v0; e_r1 = v1; end
      end
      chk("ready", {bus.req0_ready, bus.req1_ready}, {e_r0, e_r1});
      chk("alu_out", {bus.alu_op, bus.alu_shamt, bus.alu_a, bus.alu_b},
          {m_alu_op, m_alu_sh, m_alu_a, m_alu_b});
      e_vld = busy && (cycle >= exp_q[0].hs_cycle + 2);
      chk("rsp_valid", bus.rsp_valid, e_vld);
      if (bus.rsp_valid && e_vld)
        chk("rsp_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err},
            {exp_q[0].id, exp_q[0].res, exp_q[0].ovf, exp_q[0].err});
`ifdef ALU_OVF_STICKY_EN
      chk("ovf_sticky", ovf_sticky, m_sticky);
      m_sticky = m_sticky & ~ovf_clr;
      if (m_in_exec && busy && exp_q[0].ovf) m_sticky[exp_q[0].id] = 1'b1;
`endif
      m_in_exec = 1'b0;
      if (bus.rsp_valid && bus.rsp_ready && busy) begin
        rsp_log.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if ((v0 && bus.req0_ready) || (v1 && bus.req1_ready)) begin
        gid = (v1 && bus.req1_ready);
        op = gid ? bus.req1_op : bus.req0_op;
        a  = gid ? bus.req1_a : bus.req0_a;
        b  = gid ? bus.req1_b : bus.req0_b;
        sh = gid ? bus.req1_shamt : bus.req0_shamt;
        alu_ref(op, a, b, sh, t.res, t.ovf, t.err);
        t.id = gid;
        t.hs_cycle = cycle;
        exp_q.push_back(t);
        m_prio = ~gid;
        m_alu_a = a; m_alu_b = b; m_alu_sh = sh;
        if (op <= OP_MAX) m_alu_op = op;
        m_in_exec = 1'b1;
        hs_count++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_shamt = sh;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_shamt = sh;
    end
  endtask

  task automatic send(input logic id, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
    bit got = 0;
    @(posedge clk); #1;
    drive(id, op, a, b, sh);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin got = 1; break; end
    end
    if (!got) tmo("req_handshake");
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_log.size() >= target) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) tmo("rsp_wait");
  endtask

  task automatic run(input string name, input logic id, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh,
                     input logic [31:0] e_res, input logic e_ovf, input logic e_err);
    int n;
    n = rsp_log.size();
    send(id, op, a, b, sh);
    wait_rsp(n + 1);
    if (rsp_log.size() > n)
      chk(name, {rsp_log[n].id, rsp_log[n].res, rsp_log[n].ovf, rsp_log[n].err},
          {id, e_res, e_ovf, e_err});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, h0;
    bit got;
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_shamt = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_shamt = 0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_OVF_STICKY_EN
    ovf_clr = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_ovf, bus.rsp_err}, 0);
    chk("reset_alu", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt}, 0);
    chk("reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);

    run("add_12_15", 1'b0, 4'd0, 32'd12, 32'd15, 5'd0, 32'd27, 1'b0, 1'b0);
    run("add_ovf", 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd5, 5'd0, 32'h8000_0004, 1'b1, 1'b0);
`ifdef ALU_OVF_STICKY_EN
    chk("sticky_set_req1", ovf_sticky, 2'b10);
`endif
    run("sub_ovf", 1'b1, 4'd1, 32'h8000_0000, 32'd100, 5'd0, 32'h7FFF_FF9C, 1'b1, 1'b0);
    run("and_no_ovf", 1'b0, 4'd2, 32'h7FFF_FFFF, 32'd5, 5'd0, 32'd5, 1'b0, 1'b0);
    run("illegal_12", 1'b0, 4'd12, 32'h7FFF_FFFF, 32'd5, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("illegal_alu_op_held", bus.alu_op, 4'd2);
    run("lt_m13_20", 1'b1, 4'd8, -32'sd13, 32'd20, 5'd0, 32'd1, 1'b0, 1'b0);
    run("gt_m13_20", 1'b0, 4'd7, -32'sd13, 32'd20, 5'd0, 32'd0, 1'b0, 1'b0);
    run("sll_31", 1'b1, 4'd4, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    run("srl_5", 1'b0, 4'd5, 32'hFFFF_FFF0, 32'd0, 5'd5, 32'h07FF_FFFF, 1'b0, 1'b0);
    run("or", 1'b1, 4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0, 1'b0);

`ifdef ALU_OVF_STICKY_EN
    // A clear that coincides with a new overflow capture on the same bit leaves it set
    n = rsp_log.size();
    send(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
    ovf_clr = 2'b10;
    @(posedge clk); #1 ovf_clr = 2'b00;
    wait_rsp(n + 1);
    chk("sticky_set_wins", ovf_sticky, 2'b10);
    @(posedge clk); #1 ovf_clr = 2'b11;
    @(posedge clk); #1 ovf_clr = 2'b00;
    @(negedge clk);
    chk("sticky_cleared", ovf_sticky, 2'b00);
`endif

    // Backpressure: response held, competing request not accepted
    n = rsp_log.size();
    bus.rsp_ready = 1'b0;
    send(1'b0, 4'd6, 32'hFFFF_FFF0, 32'd0, 5'd5);
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1; break; end
    end
    if (!got) tmo("bp_rsp_valid");
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {bus.rsp_valid, bus.rsp_result, bus.req1_ready}, {1'b1, 32'hFFFF_FFFF, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req1_ready) begin got = 1; break; end
    end
    if (!got) tmo("bp_req1_grant");
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    wait_rsp(n + 2);
    if (rsp_log.size() >= n + 2) begin
      chk("bp_sra", {rsp_log[n].id, rsp_log[n].res}, {1'b0, 32'hFFFF_FFFF});
      chk("bp_next", {rsp_log[n+1].id, rsp_log[n+1].res}, {1'b1, 32'd2});
    end

    // Reset during EXEC: no response, priority back to RR_INIT
    n = rsp_log.size();
    send(1'b0, 4'd0, 32'd1, 32'd2, 5'd0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset_no_rsp", bus.rsp_valid, 1'b0);
    end
    chk("reset_log_unchanged", rsp_log.size(), n);

    // Contention: both continuously valid, grants alternate starting at 0
    h0 = hs_count;
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 32'd100, 32'd1, 5'd0);
    drive(1'b1, 4'd1, 32'd100, 32'd1, 5'd0);
    @(negedge clk);
    chk("prio_after_reset", {bus.req0_ready, bus.req1_ready}, 2'b10);
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (hs_count >= h0 + 6) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) tmo("contention_grants");
    @(posedge clk); #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(n + 6);
    if (rsp_log.size() >= n + 6)
      for (int k = 0; k < 6; k++)
        chk("contention_seq", {rsp_log[n+k].id, rsp_log[n+k].res},
            {k[0], (k[0] ? 32'd99 : 32'd101)});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU.
  - ALU ops: add, sub, and, or, sll, srl, sra, gt, lt.
- Accepts one operation at a time over a valid/ready handshake, drives the external ALU from registered operands, and captures its result and overflow.
- Returns one tagged response over a valid/ready handshake.
- Sits between the register-file/issue logic and the ALU instance.

Parameters:
- RR_INIT, 0, requester that holds priority after reset (0 or 1).
- OP_MAX, 8, highest legal op code; codes above it are rejected without issuing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  4  ALU op code.
- req0_a / req1_a  in  32  operand A, signed.
- req0_b / req1_b  in  32  operand B, signed.
- req0_shamt / req1_shamt  in  5  shift amount.
- alu_a  out  32  to ALU A.
- alu_b  out  32  to ALU B.
- alu_op  out  4  to ALU op.
- alu_shamt  out  5  to ALU shift_amt.
- alu_result  in  32  from ALU Result.
- alu_overflow  in  1  from ALU overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  32  captured result.
- rsp_ovf  out  1  signed overflow (add/sub only).
- rsp_err  out  1  illegal op code.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, named rst_n.
- Reset values:
  - state=IDLE, prio=RR_INIT.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_op=0, alu_shamt=0.
  - Both ready outputs 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to prio.
  - The granted reqN_ready is 1 combinationally; every other ready is 0.
  - On handshake: latch op, a, b, shamt and id into operand registers; set prio to the other requester; go to EXEC.
- EXEC (one cycle):
  - alu_* are driven from the operand registers (registered, stable for the whole cycle).
  - At the cycle end, capture rsp_result=alu_result and rsp_ovf=alu_overflow only if op is 0 or 1, else 0.
  - rsp_id is set to the latched id and rsp_err=0. Go to RESP.
- Illegal op (op > OP_MAX): EXEC still occurs, but alu_op is held at its previous value. Capture rsp_result=0, rsp_ovf=0, rsp_err=1.
- RESP:
  - rsp_valid=1 and all rsp_* are held stable until rsp_ready=1.
  - On the rsp_ready cycle, return to IDLE; rsp_valid drops on the next cycle.
  - No new request is accepted in RESP; both readies are 0.
- Latency: handshake in cycle N gives rsp_valid high in cycle N+2. Peak throughput is one op per 3 cycles.
- alu_* outputs keep their last issued values outside EXEC. This prevents spurious ALU toggling.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- A requester deasserting valid before being granted is legal; no state change.
- rst_n low in any state: return to IDLE next edge and drop the in-flight op and pending response. No response is emitted for it.

Optional Feature:
- Macro: ALU_OVF_STICKY_EN.
- When defined, two ports are added:
  - ovf_sticky  out  2  per-requester sticky overflow flags.
  - ovf_clr  in  2  per-requester clear.
- Flag behaviour:
  - Bit rsp_id is set in the EXEC capture cycle when rsp_ovf is captured as 1.
  - ovf_clr[i] clears bit i.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Reset value is 0.
- When undefined, both ports and the logic are absent; the rest of the behaviour is identical.

Test Plan:
- Single add: req0 op=0, a=12, b=15, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_result=27, rsp_ovf=0, rsp_id=0.
- Overflow: req1 op=0, a=2147483647, b=5 -> rsp_result=-2147483644, rsp_ovf=1, rsp_id=1. Then op=1, a=-2147483648, b=100 -> rsp_ovf=1.
- Contention: both valid continuously, RR_INIT=0, six ops -> rsp_id sequence 0,1,0,1,0,1. A ready is never high in EXEC or RESP.
- Backpressure: rsp_ready=0 for 5 cycles on op=6, a=0xFFFFFFF0, shamt=5 -> rsp_result=0xFFFFFFFF held stable, no new acceptance. Release -> IDLE.
- Illegal/flag ops: op=12 -> rsp_err=1, rsp_result=0. op=8, a=-13, b=20 -> rsp_result=1. Non-add op after an overflowing add -> rsp_ovf=0.
- Reset mid-op: rst_n low during EXEC -> no rsp_valid, prio=RR_INIT. With ALU_OVF_STICKY_EN: overflow on req1 sets ovf_sticky=2'b10. ovf_clr=2'b10 coinciding with a new overflow capture leaves the bit set.
